// File: rtl/pc_gen_if.sv
// Redirect/fetch bundle between the IF-stage control and pc_gen.
// The slave side is the PC generator itself.
interface pc_gen_if #(
  parameter int unsigned WIDTH = 32
);
  logic             pc_write;
  logic             exc_req;
  logic             jr_valid;
  logic [WIDTH-1:0] jr_target;
  logic             br_valid;
  logic [WIDTH-1:0] br_target;
  logic             j_valid;
  logic [WIDTH-1:0] j_target;
  logic [WIDTH-1:0] pc_o;
  logic [WIDTH-1:0] pc_plus_o;
  logic             pending_o;
  logic             misalign_o;

  modport master (
    output pc_write, exc_req,
    output jr_valid, jr_target,
    output br_valid, br_target,
    output j_valid, j_target,
    input  pc_o, pc_plus_o,
    input  pending_o, misalign_o
  );

  modport slave (
    input  pc_write, exc_req,
    input  jr_valid, jr_target,
    input  br_valid, br_target,
    input  j_valid, j_target,
    output pc_o, pc_plus_o,
    output pending_o, misalign_o
  );
endinterface

// File: rtl/pc_gen.sv
// IF-stage program counter: prioritised redirects, stall capture,
// misaligned-target reporting.
module pc_gen #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h00400000),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h80000180),
  parameter int unsigned      INSTR_BYTES  = 4
) (
  input logic    clk,
  input logic    reset,
  pc_gen_if.slave bus
);

  localparam logic [WIDTH-1:0] LOW = WIDTH'(INSTR_BYTES - 1);
  localparam logic [WIDTH-1:0] INC = WIDTH'(INSTR_BYTES);

  typedef enum logic {
    RUN,
    HOLD
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pend_addr_q;
  logic             pend_mis_q;
  logic             mis_q;

  logic             fresh_vld;
  logic [WIDTH-1:0] fresh_addr;
  logic             fresh_mis;
  logic [WIDTH-1:0] pc_plus;

  // Exceptions are handled ahead of this selector.
  always_comb begin
    fresh_vld  = 1'b1;
    fresh_addr = '0;
    fresh_mis  = 1'b0;
    if (bus.jr_valid) begin
      fresh_addr = bus.jr_target & ~LOW;
      fresh_mis  = |(bus.jr_target & LOW);
    end else if (bus.br_valid) begin
      fresh_addr = bus.br_target & ~LOW;
      fresh_mis  = |(bus.br_target & LOW);
    end else if (bus.j_valid) begin
      fresh_addr = bus.j_target & ~LOW;
      fresh_mis  = |(bus.j_target & LOW);
    end else begin
      fresh_vld  = 1'b0;
    end
  end

  assign pc_plus = pc_q + INC;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      pc_q        <= RESET_VECTOR;
      pend_addr_q <= '0;
      pend_mis_q  <= 1'b0;
      mis_q       <= 1'b0;
    end else if (bus.exc_req) begin
      state_q    <= RUN;
      pc_q       <= EXC_VECTOR;
      pend_mis_q <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          mis_q <= 1'b0;
          if (bus.pc_write) begin
            if (fresh_vld) begin
              pc_q  <= fresh_addr;
              mis_q <= fresh_mis;
            end else begin
              pc_q  <= pc_plus;
            end
          end else if (fresh_vld) begin
            state_q     <= HOLD;
            pend_addr_q <= fresh_addr;
            pend_mis_q  <= fresh_mis;
          end
        end
        // Oldest captured redirect wins; later ones are wrong-path.
        HOLD: begin
          mis_q <= 1'b0;
          if (bus.pc_write) begin
            state_q <= RUN;
            pc_q    <= pend_addr_q;
            mis_q   <= pend_mis_q;
          end
        end
      endcase
    end
  end

  assign bus.pc_o       = pc_q;
  assign bus.pc_plus_o  = pc_plus;
  assign bus.pending_o  = (state_q == HOLD);
  assign bus.misalign_o = mis_q;

endmodule
